// File: rtl/sc_leveltimer.sv
// Period timebase and tick-driven level counter for the game sequencer.
// Optional pause input and PAUSE state enabled by defining SC_LEVELTIMER_PAUSE_EN.
module sc_leveltimer #(
    parameter int unsigned TIMER_WIDTH     = 32,
    parameter int unsigned LV_WIDTH        = 8,
    parameter int unsigned STEPS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL       = 59
) (
    input  logic                   SC_LEVELTIMER_CLOCK_50,
    input  logic                   SC_LEVELTIMER_RESET_InLow,
    input  logic                   SC_LEVELTIMER_START_InLow,
`ifdef SC_LEVELTIMER_PAUSE_EN
    input  logic                   SC_LEVELTIMER_PAUSE_InHigh,
`endif
    input  logic [TIMER_WIDTH-1:0] SC_LEVELTIMER_PERIOD_In,
    output logic                   SC_LEVELTIMER_TICK_Out,
    output logic                   SC_LEVELTIMER_LEVELUP_Out,
    output logic [LV_WIDTH-1:0]    SC_LEVELTIMER_LV_Out,
    output logic                   SC_LEVELTIMER_DONE_Out,
    output logic                   SC_LEVELTIMER_RUN_Out
);

    localparam int unsigned STEP_W = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;

`ifdef SC_LEVELTIMER_PAUSE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3} state_t;
    logic pause;
    assign pause = SC_LEVELTIMER_PAUSE_InHigh;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd3} state_t;
`endif

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] shadow_q, shadow_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [LV_WIDTH-1:0]    lv_q, lv_d;
    logic                   tick_q, tick_d;
    logic                   levelup_q, levelup_d;
    logic                   done_q, done_d;
    logic                   run_q, run_d;
    logic                   advance;
    logic [TIMER_WIDTH-1:0] period_eff;

    assign period_eff = (SC_LEVELTIMER_PERIOD_In == '0) ? TIMER_WIDTH'(1) : SC_LEVELTIMER_PERIOD_In;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        step_d    = step_q;
        lv_d      = lv_q;
        tick_d    = 1'b0;
        levelup_d = 1'b0;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!SC_LEVELTIMER_START_InLow) begin
                    state_d  = ST_RUN;
                    shadow_d = period_eff;
                    count_d  = '0;
                end
            end
`ifdef SC_LEVELTIMER_PAUSE_EN
            ST_RUN: begin
                if (pause) state_d = ST_PAUSE;
                else       advance = 1'b1;
            end
            // The resume edge counts, so the delay equals the number of paused edges.
            ST_PAUSE: begin
                if (!pause) begin
                    state_d = ST_RUN;
                    advance = 1'b1;
                end
            end
`else
            ST_RUN:  advance = 1'b1;
`endif
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (count_q == shadow_q - TIMER_WIDTH'(1)) begin
                tick_d   = 1'b1;
                count_d  = '0;
                shadow_d = period_eff;
                if (step_q == STEP_W'(STEPS_PER_LEVEL - 1)) begin
                    step_d    = '0;
                    lv_d      = lv_q + LV_WIDTH'(1);
                    levelup_d = 1'b1;
                    if (lv_d == LV_WIDTH'(MAX_LEVEL)) state_d = ST_DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end else begin
                count_d = count_q + TIMER_WIDTH'(1);
            end
        end

        run_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge SC_LEVELTIMER_CLOCK_50) begin
        if (!SC_LEVELTIMER_RESET_InLow) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shadow_q  <= '0;
            step_q    <= '0;
            lv_q      <= '0;
            tick_q    <= 1'b0;
            levelup_q <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            step_q    <= step_d;
            lv_q      <= lv_d;
            tick_q    <= tick_d;
            levelup_q <= levelup_d;
            done_q    <= done_d;
            run_q     <= run_d;
        end
    end

    assign SC_LEVELTIMER_TICK_Out    = tick_q;
    assign SC_LEVELTIMER_LEVELUP_Out = levelup_q;
    assign SC_LEVELTIMER_LV_Out      = lv_q;
    assign SC_LEVELTIMER_DONE_Out    = done_q;
    assign SC_LEVELTIMER_RUN_Out     = run_q;

endmodule

// File: tb/tb_sc_leveltimer.sv
// Directed bench for sc_leveltimer: default-parameter instance plus a MAX_LEVEL=2, STEPS=1 instance.
module tb_sc_leveltimer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, start_a = 1'b1;
    logic [31:0] per_a = 32'd4;
    logic        tick_a, lu_a, done_a, run_a;
    logic [7:0]  lv_a;

    logic        rst_b = 1'b0, start_b = 1'b1;
    logic [31:0] per_b = 32'd2;
    logic        tick_b, lu_b, done_b, run_b;
    logic [7:0]  lv_b;

`ifdef SC_LEVELTIMER_PAUSE_EN
    logic        pause_a = 1'b0;
    logic        pause_b = 1'b0;
`endif

    sc_leveltimer dut_a (
        .SC_LEVELTIMER_CLOCK_50    (clk),
        .SC_LEVELTIMER_RESET_InLow (rst_a),
        .SC_LEVELTIMER_START_InLow (start_a),
`ifdef SC_LEVELTIMER_PAUSE_EN
        .SC_LEVELTIMER_PAUSE_InHigh(pause_a),
`endif
        .SC_LEVELTIMER_PERIOD_In   (per_a),
        .SC_LEVELTIMER_TICK_Out    (tick_a),
        .SC_LEVELTIMER_LEVELUP_Out (lu_a),
        .SC_LEVELTIMER_LV_Out      (lv_a),
        .SC_LEVELTIMER_DONE_Out    (done_a),
        .SC_LEVELTIMER_RUN_Out     (run_a)
    );

    sc_leveltimer #(
        .TIMER_WIDTH    (32),
        .LV_WIDTH       (8),
        .STEPS_PER_LEVEL(1),
        .MAX_LEVEL      (2)
    ) dut_b (
        .SC_LEVELTIMER_CLOCK_50    (clk),
        .SC_LEVELTIMER_RESET_InLow (rst_b),
        .SC_LEVELTIMER_START_InLow (start_b),
`ifdef SC_LEVELTIMER_PAUSE_EN
        .SC_LEVELTIMER_PAUSE_InHigh(pause_b),
`endif
        .SC_LEVELTIMER_PERIOD_In   (per_b),
        .SC_LEVELTIMER_TICK_Out    (tick_b),
        .SC_LEVELTIMER_LEVELUP_Out (lu_b),
        .SC_LEVELTIMER_LV_Out      (lv_b),
        .SC_LEVELTIMER_DONE_Out    (done_b),
        .SC_LEVELTIMER_RUN_Out     (run_b)
    );

    typedef struct {
        logic        rst_n;
        logic        start_n;
        logic [31:0] period;
        logic        tick;
        logic        levelup;
        logic [7:0]  lv;
        logic        done;
        logic        run;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic s, input logic [31:0] p,
                       input logic t, input logic l, input logic [7:0] lv,
                       input logic d, input logic rn);
        vec_t v;
        v.rst_n = r; v.start_n = s; v.period = p;
        v.tick = t; v.levelup = l; v.lv = lv; v.done = d; v.run = rn;
        vecs.push_back(v);
    endtask

    // Packed as {tick, levelup, lv[7:0], done, run}.
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got tick=%b lu=%b lv=%0d done=%b run=%b, want tick=%b lu=%b lv=%0d done=%b run=%b",
                     name, act[11], act[10], act[9:2], act[1], act[0],
                     exp[11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [11:0] pk(input logic t, input logic l, input logic [7:0] lv,
                                       input logic d, input logic r);
        return {t, l, lv, d, r};
    endfunction

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        // Reset, start with period 4, period change 4->10 mid-period, then period 0.
        add(0, 1, 4,  0, 0, 0, 0, 0);
        add(1, 1, 4,  0, 0, 0, 0, 0);
        add(1, 0, 4,  0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 4, 0, 0, 0, 0, 1);
        add(1, 1, 4,  1, 0, 0, 0, 1);
        add(1, 0, 4,  0, 0, 0, 0, 1);
        add(1, 1, 4,  0, 0, 0, 0, 1);
        add(1, 1, 4,  0, 0, 0, 0, 1);
        add(1, 1, 4,  1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 10, 0, 0, 0, 0, 1);
        add(1, 1, 10, 1, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) add(1, (i == 4) ? 1'b0 : 1'b1, 10, 0, 0, 0, 0, 1);
        add(1, 1, 0,  1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 1, 0, 1);
        add(1, 1, 0,  1, 1, 2, 0, 1);
        add(1, 1, 0,  1, 0, 2, 0, 1);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_a = vecs[i].rst_n; start_a = vecs[i].start_n; per_a = vecs[i].period;
            step_edge();
            check($sformatf("vec%0d", i), {tick_a, lu_a, lv_a, done_a, run_a},
                  pk(vecs[i].tick, vecs[i].levelup, vecs[i].lv, vecs[i].done, vecs[i].run));
        end

        // Period 3: LEVELUP on every 4th tick, LV 1..3.
        rst_a = 0; start_a = 1; per_a = 3;
        step_edge();
        check("p3_reset", {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 0, 0, 0));
        rst_a = 1; start_a = 0;
        step_edge();
        check("p3_start", {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 0, 0, 1));
        start_a = 1;
        for (int k = 1; k <= 36; k++) begin
            logic t;
            logic l;
            step_edge();
            t = (k % 3 == 0);
            n = k / 3;
            l = t && (n % 4 == 0);
            check($sformatf("p3_k%0d", k), {tick_a, lu_a, lv_a, done_a, run_a},
                  pk(t, l, 8'(n / 4), 0, 1));
        end

        // Reset mid-period (count 2 of 5, LV 1), then clean restart.
        rst_a = 0; per_a = 5;
        step_edge();
        rst_a = 1; start_a = 0;
        step_edge();
        start_a = 1;
        for (int k = 1; k <= 22; k++) step_edge();
        check("p5_lv1", {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 1, 0, 1));
        rst_a = 0;
        step_edge();
        check("midreset", {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 0, 0, 0));
        rst_a = 1;
        step_edge();
        check("idle_after_reset", {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 0, 0, 0));
        start_a = 0;
        step_edge();
        start_a = 1;
        check("restart", {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 0, 0, 1));
        for (int k = 1; k <= 5; k++) begin
            step_edge();
            check($sformatf("restart_k%0d", k), {tick_a, lu_a, lv_a, done_a, run_a},
                  pk(k == 5, 0, 0, 0, 1));
        end

        // MAX_LEVEL=2, STEPS=1, PERIOD=2: saturation into DONE.
        step_edge();
        check("b_reset", {tick_b, lu_b, lv_b, done_b, run_b}, pk(0, 0, 0, 0, 0));
        rst_b = 1; start_b = 0;
        step_edge();
        start_b = 1;
        check("b_start", {tick_b, lu_b, lv_b, done_b, run_b}, pk(0, 0, 0, 0, 1));
        step_edge();
        check("b_e1", {tick_b, lu_b, lv_b, done_b, run_b}, pk(0, 0, 0, 0, 1));
        step_edge();
        check("b_e2", {tick_b, lu_b, lv_b, done_b, run_b}, pk(1, 1, 1, 0, 1));
        step_edge();
        check("b_e3", {tick_b, lu_b, lv_b, done_b, run_b}, pk(0, 0, 1, 0, 1));
        step_edge();
        check("b_done", {tick_b, lu_b, lv_b, done_b, run_b}, pk(1, 1, 2, 1, 0));
        start_b = 0;
        for (int k = 0; k < 5; k++) begin
            step_edge();
            check($sformatf("b_hold%0d", k), {tick_b, lu_b, lv_b, done_b, run_b}, pk(0, 0, 2, 1, 0));
        end
        rst_b = 0; start_b = 1;
        step_edge();
        check("b_reset_done", {tick_b, lu_b, lv_b, done_b, run_b}, pk(0, 0, 0, 0, 0));

`ifdef SC_LEVELTIMER_PAUSE_EN
        // Pause 7 edges at count 1 of period 4 delays the tick by 7.
        rst_a = 0; per_a = 4;
        step_edge();
        rst_a = 1; start_a = 0;
        step_edge();
        start_a = 1;
        step_edge();
        pause_a = 1;
        for (int k = 0; k < 7; k++) begin
            step_edge();
            check($sformatf("pause%0d", k), {tick_a, lu_a, lv_a, done_a, run_a}, pk(0, 0, 0, 0, 0));
        end
        pause_a = 0;
        for (int k = 1; k <= 3; k++) begin
            step_edge();
            check($sformatf("resume%0d", k), {tick_a, lu_a, lv_a, done_a, run_a}, pk(k == 3, 0, 0, 0, 1));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
